// File: rtl/ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_fsm_if
// Description : Fetch, data-memory and control-field bundle of ctrl_fsm.
//               master = controller side, slave = core/memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface ctrl_fsm_if #(
    parameter int OPCODE_W  = 4,
    parameter int OPERAND_W = 4
);
    localparam int INSTR_W = OPCODE_W + OPERAND_W;

    logic [INSTR_W-1:0]   instr;
    logic                 instr_valid;
    logic                 instr_ready;
    logic                 mem_req;
    logic                 mem_ack;
    logic                 mem_we;
    logic [OPERAND_W-1:0] addr_offset;
    logic [2:0]           alu_op;
    logic [2:0]           alu_shamt;
    logic                 alu_en;
    logic                 reg_we;
    logic [OPERAND_W-1:0] nibble_out;
    logic [OPERAND_W-1:0] reg_sel;
    logic [1:0]           reg16_src;
    logic [1:0]           reg16_dst;
    logic                 pc_inc;
    logic                 busy;
    logic                 fault;

    modport master (
        input  instr, instr_valid, mem_ack,
        output instr_ready, mem_req, mem_we, addr_offset, alu_op, alu_shamt,
               alu_en, reg_we, nibble_out, reg_sel, reg16_src, reg16_dst,
               pc_inc, busy, fault
    );

    modport slave (
        output instr, instr_valid, mem_ack,
        input  instr_ready, mem_req, mem_we, addr_offset, alu_op, alu_shamt,
               alu_en, reg_we, nibble_out, reg_sel, reg16_src, reg16_dst,
               pc_inc, busy, fault
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_fsm
// Description : Multi-cycle instruction controller (IDLE/FETCH/DECODE/EXEC/MEM)
//               with registered control fields and a req/ack memory cycle.
//               Define CTRL_FSM_MEM_TIMEOUT_EN to add the MEM watchdog + fault.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_fsm #(
    parameter int OPCODE_W   = 4,
    parameter int OPERAND_W  = 4,
    parameter int OPCODE_LDB = 8,
    parameter int OPCODE_STB = 9
`ifdef CTRL_FSM_MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 15
`endif
) (
    input  wire logic  clk,
    input  wire logic  rst,
    ctrl_fsm_if.master bus
);

    localparam int INSTR_W = OPCODE_W + OPERAND_W;
    localparam logic [OPCODE_W-1:0] c_LDB = OPCODE_W'(OPCODE_LDB);
    localparam logic [OPCODE_W-1:0] c_STB = OPCODE_W'(OPCODE_STB);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [INSTR_W-1:0]   instr_q;
    logic [OPERAND_W-1:0] operand_q;
    logic [2:0]           alu_op_q;
    logic [2:0]           alu_shamt_q;
    logic [1:0]           reg16_src_q;
    logic [1:0]           reg16_dst_q;
    logic                 arith_q;
    logic                 store_q;

    logic [OPCODE_W-1:0]  w_opcode;
    logic [OPERAND_W-1:0] w_operand;
    logic                 w_arith;
    logic                 w_mem;
    logic                 w_accept;
    logic                 w_timeout;

    logic w_instr_ready;
    logic w_busy;
    logic w_alu_en;
    logic w_reg_we;
    logic w_pc_inc;
    logic w_mem_req;
    logic w_mem_we;

    assign w_opcode  = instr_q[INSTR_W-1 -: OPCODE_W];
    assign w_operand = instr_q[OPERAND_W-1:0];
    // A clear opcode MSB means arithmetic, even if LDB/STB were given such a code.
    assign w_arith   = ~w_opcode[OPCODE_W-1];
    assign w_mem     = w_opcode[OPCODE_W-1] && ((w_opcode == c_LDB) || (w_opcode == c_STB));
    assign w_accept  = (state_q == S_FETCH) && bus.instr_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= '0;
        end else if (w_accept) begin
            instr_q <= bus.instr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            operand_q   <= '0;
            alu_op_q    <= '0;
            alu_shamt_q <= '0;
            reg16_src_q <= '0;
            reg16_dst_q <= '0;
            arith_q     <= 1'b0;
            store_q     <= 1'b0;
        end else if (state_q == S_DECODE) begin
            operand_q   <= w_operand;
            alu_op_q    <= w_opcode[2:0];
            alu_shamt_q <= w_operand[2:0];
            reg16_src_q <= w_operand[3:2];
            reg16_dst_q <= w_operand[1:0];
            arith_q     <= w_arith;
            store_q     <= (w_opcode == c_STB);
        end
    end

`ifdef CTRL_FSM_MEM_TIMEOUT_EN
    // Compare against limit-1 so mem_req stays high for exactly TIMEOUT_CYCLES cycles.
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt_q;
    logic       fault_q;

    assign w_timeout = (state_q == S_MEM) && !bus.mem_ack && (tmo_cnt_q == c_TIMEOUT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            if (state_q == S_DECODE) begin
                tmo_cnt_q <= '0;
            end else if ((state_q == S_MEM) && !bus.mem_ack) begin
                tmo_cnt_q <= tmo_cnt_q + 8'd1;
            end
            if (w_timeout) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign bus.fault = fault_q;
`else
    assign w_timeout = 1'b0;
    assign bus.fault = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        w_instr_ready = 1'b0;
        w_busy        = 1'b0;
        w_alu_en      = 1'b0;
        w_reg_we      = 1'b0;
        w_pc_inc      = 1'b0;
        w_mem_req     = 1'b0;
        w_mem_we      = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                w_instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                w_busy  = 1'b1;
                state_d = w_mem ? S_MEM : S_EXEC;
            end
            S_EXEC: begin
                w_busy   = 1'b1;
                w_alu_en = arith_q;
                w_reg_we = ~arith_q;
                w_pc_inc = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM: begin
                w_busy    = 1'b1;
                w_mem_req = 1'b1;
                w_mem_we  = store_q;
                if (bus.mem_ack) begin
                    w_pc_inc = 1'b1;
                    state_d  = S_FETCH;
                end else if (w_timeout) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.instr_ready = w_instr_ready;
    assign bus.busy        = w_busy;
    assign bus.alu_en      = w_alu_en;
    assign bus.reg_we      = w_reg_we;
    assign bus.pc_inc      = w_pc_inc;
    assign bus.mem_req     = w_mem_req;
    assign bus.mem_we      = w_mem_we;

    assign bus.addr_offset = operand_q;
    assign bus.nibble_out  = operand_q;
    assign bus.reg_sel     = operand_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_shamt   = alu_shamt_q;
    assign bus.reg16_src   = reg16_src_q;
    assign bus.reg16_dst   = reg16_dst_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_fsm
// Description : Self-checking bench for ctrl_fsm; retired-instruction fields
//               are compared against a queue of accepted instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_fsm;

    localparam int         OPC_W = 4;
    localparam int         OPR_W = 4;
    localparam logic [3:0] LDB   = 4'd8;
    localparam logic [3:0] STB   = 4'd9;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ctrl_fsm_if #(.OPCODE_W(OPC_W), .OPERAND_W(OPR_W)) bus ();

    ctrl_fsm #(
        .OPCODE_W  (OPC_W),
        .OPERAND_W (OPR_W),
        .OPCODE_LDB(8),
        .OPCODE_STB(9)
`ifdef CTRL_FSM_MEM_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(3)
`endif
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [7:0] sb[$];
    logic prev_pc = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Every pc_inc retires the oldest accepted instruction; its fields must match the model.
    always @(negedge clk) begin : mon
        logic [7:0] e;
        logic [3:0] op;
        logic       arith, mem;
        if (rst) begin
            prev_pc <= 1'b0;
        end else begin
            prev_pc <= bus.pc_inc;
            if (bus.pc_inc) begin
                check("pc_inc_width", prev_pc, 0);
                check("pc_inc_has_txn", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e     = sb.pop_front();
                    op    = e[7:4];
                    arith = ~op[3];
                    mem   = op[3] && ((op == LDB) || (op == STB));
                    check("alu_op",      bus.alu_op,      op[2:0]);
                    check("alu_shamt",   bus.alu_shamt,   e[2:0]);
                    check("addr_offset", bus.addr_offset, e[3:0]);
                    check("nibble_out",  bus.nibble_out,  e[3:0]);
                    check("reg_sel",     bus.reg_sel,     e[3:0]);
                    check("reg16_src",   bus.reg16_src,   e[3:2]);
                    check("reg16_dst",   bus.reg16_dst,   e[1:0]);
                    check("alu_en",      bus.alu_en,      arith);
                    check("reg_we",      bus.reg_we,      !arith && !mem);
                    check("mem_req",     bus.mem_req,     mem);
                    check("mem_we",      bus.mem_we,      op == STB);
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!bus.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("fetch_ready_wait", bus.instr_ready, 1);
    endtask

    // One instruction; ack_cyc = MEM cycle number in which mem_ack is raised.
    task automatic do_instr(input logic [7:0] ins, input int ack_cyc);
        logic [3:0] op;
        logic       is_mem;
        int         c0;
        op     = ins[7:4];
        is_mem = op[3] && ((op == LDB) || (op == STB));
        @(posedge clk);
        #1;
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        wait_ready();
        sb.push_back(ins);
        c0 = cyc;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        @(negedge clk);
        check("dec_busy",    bus.busy,        1);
        check("dec_ready",   bus.instr_ready, 0);
        check("dec_pc_inc",  bus.pc_inc,      0);
        check("dec_mem_req", bus.mem_req,     0);
        if (!is_mem) begin
            @(negedge clk);
            check("exec_pc_inc",  bus.pc_inc,  1);
            check("exec_mem_req", bus.mem_req, 0);
        end else begin
            for (int k = 1; k <= ack_cyc; k++) begin
                @(posedge clk);
                #1;
                bus.mem_ack = (k == ack_cyc);
                @(negedge clk);
                check("mem_req_hold", bus.mem_req,     1);
                check("mem_we_hold",  bus.mem_we,      op == STB);
                check("mem_addr",     bus.addr_offset, ins[3:0]);
                check("mem_pc_inc",   bus.pc_inc,      k == ack_cyc);
            end
            @(posedge clk);
            #1;
            bus.mem_ack = 1'b0;
        end
        wait_ready();
        check("ret_pc_inc",   bus.pc_inc,  0);
        check("ret_alu_en",   bus.alu_en,  0);
        check("ret_mem_req",  bus.mem_req, 0);
        check("instr_cycles", cyc - c0,    is_mem ? 2 + ack_cyc : 3);
    endtask

    task automatic back_to_back();
        logic [7:0] prog[5] = '{8'h23, 8'h5A, 8'hC7, 8'h81, 8'h34};
        int last = 0;
        @(posedge clk);
        #1;
        bus.mem_ack     = 1'b1;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.instr = prog[i];
            wait_ready();
            sb.push_back(prog[i]);
            if (i > 0) check("b2b_gap", cyc - last, 3);
            last = cyc;
            @(posedge clk);
            #1;
        end
        bus.instr_valid = 1'b0;
        wait_ready();
        bus.mem_ack = 1'b0;
    endtask

    task automatic reset_mid_mem();
        @(posedge clk);
        #1;
        bus.instr       = {STB, 4'h5};
        bus.instr_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_mem_req", bus.mem_req,     1);
        check("pre_rst_addr",    bus.addr_offset, 5);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mem_req", bus.mem_req,     0);
        check("rst_busy",    bus.busy,        0);
        check("rst_addr",    bus.addr_offset, 0);
        check("rst_alu_op",  bus.alu_op,      0);
        check("rst_ready",   bus.instr_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_idle_ready", bus.instr_ready, 0);
        @(negedge clk);
        check("rst_fetch_ready", bus.instr_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.instr       = '0;
        bus.instr_valid = 1'b0;
        bus.mem_ack     = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs", {bus.instr_ready, bus.busy, bus.mem_req, bus.mem_we,
                             bus.alu_en, bus.reg_we, bus.pc_inc, bus.fault}, 0);
        check("reset_fields", {bus.alu_op, bus.alu_shamt, bus.addr_offset, bus.nibble_out,
                               bus.reg_sel, bus.reg16_src, bus.reg16_dst}, 0);
        @(posedge clk);
        #1;
        bus.instr       = 8'h23;
        bus.instr_valid = 1'b1;
        rst             = 1'b0;
        @(negedge clk);
        check("idle_ready", bus.instr_ready, 0);
        check("idle_busy",  bus.busy,        0);
        @(negedge clk);
        check("fetch_ready", bus.instr_ready, 1);
        bus.instr_valid = 1'b0;

        do_instr(8'h23, 0);
        do_instr({STB, 4'h5}, 4);
        do_instr({LDB, 4'hA}, 1);
        do_instr(8'hC7, 0);
        back_to_back();
        reset_mid_mem();

`ifdef CTRL_FSM_MEM_TIMEOUT_EN
        begin
            int c0;
            @(posedge clk);
            #1;
            bus.instr       = {STB, 4'h3};
            bus.instr_valid = 1'b1;
            wait_ready();
            c0 = cyc;
            @(posedge clk);
            #1;
            bus.instr_valid = 1'b0;
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check("tmo_mem_req", bus.mem_req, 1);
                check("tmo_pc_inc",  bus.pc_inc,  0);
                check("tmo_fault_pre", bus.fault, 0);
            end
            @(negedge clk);
            check("tmo_drop",   bus.mem_req,     0);
            check("tmo_fault",  bus.fault,       1);
            check("tmo_ready",  bus.instr_ready, 1);
            check("tmo_cycles", cyc - c0,        5);
            do_instr(8'h23, 0);
            check("tmo_fault_sticky", bus.fault, 1);
        end
`else
        check("fault_tied_low", bus.fault, 0);
`endif

        check("sb_leftover", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
